// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM encoding,
// owner tags, response codes and the registered bus request record.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_D       = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;

  // Wide enough for MAX_D_STREAK up to 15.
  localparam int STREAK_W = 4;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } bus_req_t;

  // Pick the 32-bit instruction out of a 64-bit beat.
  function automatic logic [31:0] word_sel(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/arb_grant_policy.sv
// Fairness rule for the shared memory port: data wins by default, but a
// pending fetch is granted once data has won MAX_D_STREAK times in a row.
module arb_grant_policy
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic inst_valid,
  input  logic data_valid,
  output logic grant_inst,
  output logic grant_data
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    streak_d   = streak_q;

    if (sample_en) begin
      if (data_valid && !(inst_valid && (streak_q >= STREAK_MAX))) begin
        grant_data = 1'b1;
      end else if (inst_valid) begin
        grant_inst = 1'b1;
      end
    end

    // The streak only measures data wins that actually held off a fetch.
    if (grant_inst) begin
      streak_d = '0;
    end else if (grant_data) begin
      if (!inst_valid) begin
        streak_d = '0;
      end else if (streak_q != STREAK_SAT) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Registered arbiter for the core's single memory port: grants fetch or
// load/store, holds the bus request stable, and answers with a one-cycle ready.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [63:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_rdata,
  output logic [1:0]  inst_resp,
  input  logic        data_valid,
  input  logic        data_we,
  input  logic [63:0] data_addr,
  input  logic [63:0] data_wdata,
  input  logic [7:0]  data_wmask,
  input  logic [1:0]  data_size,
  output logic        data_ready,
  output logic [63:0] data_rdata,
  output logic [1:0]  data_resp,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  output logic [63:0] bus_addr,
  output logic [1:0]  bus_size,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic [63:0] bus_rdata,
  input  logic [1:0]  bus_resp,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam bit              WD_EN    = (TIMEOUT != 0);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  bus_req_t        req_q, req_d;
  logic            sel_hi_q, sel_hi_d;
  logic [WD_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [31:0]     inst_rdata_q, inst_rdata_d;
  logic [1:0]      inst_resp_q, inst_resp_d;
  logic [63:0]     data_rdata_q, data_rdata_d;
  logic [1:0]      data_resp_q, data_resp_d;

  logic            cap_en;
  logic [63:0]     cap_rdata;
  logic [1:0]      cap_resp;
  logic            grant_inst, grant_data;

  // The low fetch address bits never reach the bus; bit 2 is kept separately.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^inst_addr[1:0];

  arb_grant_policy #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_policy (
    .clk       (clk),
    .rst       (rst),
    .sample_en (state_q == ST_IDLE),
    .inst_valid(inst_valid),
    .data_valid(data_valid),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    sel_hi_d     = sel_hi_q;
    wdog_d       = wdog_q;
    wdog_inc     = wdog_q + 1'b1;
    inst_rdata_d = inst_rdata_q;
    inst_resp_d  = inst_resp_q;
    data_rdata_d = data_rdata_q;
    data_resp_d  = data_resp_q;
    cap_en       = 1'b0;
    cap_rdata    = '0;
    cap_resp     = RESP_OKAY;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          owner_d     = OWNER_DATA;
          req_d.re    = ~data_we;
          req_d.we    = data_we;
          req_d.size  = data_size;
          req_d.addr  = data_addr;
          req_d.wdata = data_wdata;
          req_d.wmask = data_wmask;
          wdog_d      = '0;
          state_d     = ST_BUSY;
        end else if (grant_inst) begin
          owner_d     = OWNER_INST;
          req_d.re    = 1'b1;
          req_d.we    = 1'b0;
          req_d.size  = SIZE_D;
          req_d.addr  = {inst_addr[63:3], 3'b000};
          req_d.wdata = '0;
          req_d.wmask = '0;
          sel_hi_d    = inst_addr[2];
          wdog_d      = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A completion in the expiry cycle still counts as a real response.
        if (bus_ready) begin
          cap_en    = 1'b1;
          cap_rdata = bus_rdata;
          cap_resp  = bus_resp;
          state_d   = ST_RESP;
        end else if (WD_EN && (wdog_inc == WD_LIMIT)) begin
          cap_en    = 1'b1;
          cap_rdata = '0;
          cap_resp  = RESP_TIMEOUT;
          state_d   = ST_RESP;
        end else if (WD_EN) begin
          wdog_d = wdog_inc;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Responses land in the owner's registers and persist until the next one.
    if (cap_en) begin
      if (owner_q == OWNER_INST) begin
        inst_rdata_d = word_sel(cap_rdata, sel_hi_q);
        inst_resp_d  = cap_resp;
      end else begin
        data_rdata_d = cap_rdata;
        data_resp_d  = cap_resp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_INST;
      req_q        <= '0;
      sel_hi_q     <= 1'b0;
      wdog_q       <= '0;
      inst_rdata_q <= '0;
      inst_resp_q  <= '0;
      data_rdata_q <= '0;
      data_resp_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      req_q        <= req_d;
      sel_hi_q     <= sel_hi_d;
      wdog_q       <= wdog_d;
      inst_rdata_q <= inst_rdata_d;
      inst_resp_q  <= inst_resp_d;
      data_rdata_q <= data_rdata_d;
      data_resp_q  <= data_resp_d;
    end
  end

  // Ready is qualified by the live valid so a flushed requester gets no pulse.
  assign inst_ready       = (state_q == ST_RESP) && (owner_q == OWNER_INST) && inst_valid;
  assign data_ready       = (state_q == ST_RESP) && (owner_q == OWNER_DATA) && data_valid;
  assign inst_rdata       = inst_rdata_q;
  assign inst_resp        = inst_resp_q;
  assign data_rdata       = data_rdata_q;
  assign data_resp        = data_resp_q;

  assign bus_valid        = (state_q == ST_BUSY);
  assign bus_read_enable  = req_q.re;
  assign bus_write_enable = req_q.we;
  assign bus_addr         = req_q.addr;
  assign bus_size         = req_q.size;
  assign bus_wdata        = req_q.wdata;
  assign bus_wmask        = req_q.wmask;

  assign busy             = (state_q != ST_IDLE) || inst_valid || data_valid;
  assign dbg_state        = state_q;

endmodule
